pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator, successor to the fixed six-channel 3-bit-duty PWM block driven from the AXI register file. Each channel takes one 32-bit control word (a slice of the register file) and provides:
- a programmable period, duty and power-of-two prescaler;
- double-buffered (glitch-free) updates and output polarity;
- a per-period tick.

Sits between the AXI register bank and the board PWM pins, in the `clk_axi` domain.

---
 rtl/pwm_bank.sv | 151 +++++++++++++++
 tb/tb_pwm_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Purpose  : N_CH-channel PWM generator with period, duty and prescaler
//            settings that take effect glitch-free at the period boundary.
//            Define PWM_BANK_SYNC_EN to make every channel load its new
//            settings at channel 0's wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_bank #(
    parameter int N_CH  = 6,
    parameter int CNT_W = 12
) (
    input  logic                clk_axi,
    input  logic                rst_axi,
    input  logic [N_CH*32-1:0]  ctrl_in,
    output logic [N_CH-1:0]     pwm_out,
    output logic [N_CH-1:0]     period_tick,
    output logic [N_CH-1:0]     upd_pending
);

    localparam int               c_pre_w   = 15;
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

`ifdef PWM_BANK_SYNC_EN
    // Channel 0 is the timing master: loads wait for its wrap unless it is idle.
    logic w_sync_wrap;
    logic w_sync_load_ok;
    assign w_sync_load_ok = w_sync_wrap | ~ctrl_in[30] | ctrl_in[29];
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [31:0]        w_ctrl;
        logic [CNT_W-1:0]   w_f_period;
        logic [CNT_W-1:0]   w_f_duty;
        logic [3:0]         w_f_pre;
        logic               w_upd;
        logic               w_srst;
        logic               w_en;
        logic               w_inv;
        logic               w_run;
        logic               w_upd_edge;
        logic               w_tick;
        logic               w_wrap;
        logic               w_load;
        logic [c_pre_w-1:0] w_pre_max;

        logic [c_pre_w-1:0] r_pre_cnt;
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   r_act_period;
        logic [CNT_W-1:0]   r_act_duty;
        logic [3:0]         r_act_pre;
        logic [CNT_W-1:0]   r_sh_period;
        logic [CNT_W-1:0]   r_sh_duty;
        logic [3:0]         r_sh_pre;
        logic               r_pending;
        logic               r_upd_d;
        logic               r_wrap_q;
        logic               r_ptick;
        logic               r_pwm;

        assign w_ctrl     = ctrl_in[i*32 +: 32];
        assign w_f_period = w_ctrl[CNT_W-1:0];
        assign w_f_duty   = w_ctrl[12 +: CNT_W];
        assign w_f_pre    = w_ctrl[27:24];
        assign w_upd      = w_ctrl[28];
        assign w_srst     = w_ctrl[29];
        assign w_en       = w_ctrl[30];
        assign w_inv      = w_ctrl[31];

        assign w_run      = w_en & ~w_srst;
        assign w_upd_edge = w_upd & ~r_upd_d;
        // Low r_act_pre bits set: terminal count of the prescaler.
        assign w_pre_max  = ~({c_pre_w{1'b1}} << r_act_pre);
        // >= rather than == keeps the prescaler safe if PRE shrinks mid-count.
        assign w_tick     = w_run & (r_pre_cnt >= w_pre_max);
        assign w_wrap     = w_tick & (r_cnt >= r_act_period);

`ifdef PWM_BANK_SYNC_EN
        assign w_load = r_pending & w_sync_load_ok;
        if (i == 0) begin : g_sync_src
            assign w_sync_wrap = w_wrap;
        end
`else
        assign w_load = r_pending & (w_wrap | ~w_en);
`endif

        always_ff @(posedge clk_axi) begin
            if (rst_axi) begin
                r_pre_cnt    <= '0;
                r_cnt        <= '0;
                r_act_period <= '0;
                r_act_duty   <= '0;
                r_act_pre    <= '0;
                r_sh_period  <= '0;
                r_sh_duty    <= '0;
                r_sh_pre     <= '0;
                r_pending    <= 1'b0;
                r_upd_d      <= 1'b0;
                r_wrap_q     <= 1'b0;
                r_ptick      <= 1'b0;
                r_pwm        <= 1'b0;
            end else begin
                r_upd_d <= w_upd;
                if (w_srst) begin
                    r_pre_cnt    <= '0;
                    r_cnt        <= '0;
                    r_pending    <= 1'b0;
                    r_wrap_q     <= 1'b0;
                    r_ptick      <= 1'b0;
                    r_act_period <= w_f_period;
                    r_act_duty   <= w_f_duty;
                    r_act_pre    <= w_f_pre;
                end else begin
                    // Tick is delayed twice so it lines up with the first
                    // registered output sample of the new period.
                    r_wrap_q <= w_wrap;
                    r_ptick  <= r_wrap_q;
                    if (w_run) begin
                        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + c_pre_one;
                    end
                    if (w_tick) begin
                        r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_one;
                    end
                    if (w_load) begin
                        r_act_period <= r_sh_period;
                        r_act_duty   <= r_sh_duty;
                        r_act_pre    <= r_sh_pre;
                    end
                    // An edge coinciding with a load re-arms for the next wrap.
                    if (w_upd_edge) begin
                        r_sh_period <= w_f_period;
                        r_sh_duty   <= w_f_duty;
                        r_sh_pre    <= w_f_pre;
                        r_pending   <= 1'b1;
                    end else if (w_load) begin
                        r_pending <= 1'b0;
                    end
                end
                r_pwm <= w_run ? ((r_cnt < r_act_duty) ^ w_inv) : w_inv;
            end
        end

        assign pwm_out[i]     = r_pwm;
        assign period_tick[i] = r_ptick;
        assign upd_pending[i] = r_pending;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_bank
// Purpose  : Directed vector bench for pwm_bank (two channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;

    localparam int N_CH  = 2;
    localparam int CNT_W = 12;

    localparam logic [31:0] c_upd  = 32'h1000_0000;
    localparam logic [31:0] c_srst = 32'h2000_0000;
    localparam logic [31:0] c_en   = 32'h4000_0000;
    localparam logic [31:0] c_inv  = 32'h8000_0000;

    logic                clk_axi = 1'b0;
    logic                rst_axi;
    logic [N_CH*32-1:0]  ctrl_in;
    logic [N_CH-1:0]     pwm_out;
    logic [N_CH-1:0]     period_tick;
    logic [N_CH-1:0]     upd_pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] ctrl;
        int          exp_first;
        int          exp_high;
        int          exp_ticks;
        int          exp_ft;
    } vec_t;

    vec_t vecs[10];

    pwm_bank #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_axi     (clk_axi),
        .rst_axi     (rst_axi),
        .ctrl_in     (ctrl_in),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .upd_pending (upd_pending)
    );

    always #5 clk_axi = ~clk_axi;

    function automatic logic [31:0] mk(input int period, input int duty, input int pre);
        return (32'(pre) << 24) | (32'(duty) << 12) | 32'(period);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_axi);
        #1;
    endtask

    // SRST pulse with the new word, then release; returns in the cycle where
    // pwm_out shows the cnt=0 sample.
    task automatic start_ch0(input logic [31:0] c);
        ctrl_in[31:0] = c | c_srst;
        step();
        ctrl_in[31:0] = c;
        step();
    endtask

    initial begin
        int          hi;
        int          tk;
        int          ft;
        int          first;
        logic [31:0] pw;
        logic [31:0] pd;
        logic [31:0] tm;
        logic [31:0] p1;

        vecs[0] = '{"p9d5",     c_en | mk(9, 5, 0),         1, 20,  3, 10};
        vecs[1] = '{"pre1",     c_en | mk(9, 5, 1),         1, 20,  1, 20};
        vecs[2] = '{"duty0",    c_en | mk(9, 0, 0),         0,  0,  3, 10};
        vecs[3] = '{"duty_gt",  c_en | mk(9, 12, 0),        1, 40,  3, 10};
        vecs[4] = '{"inv_d0",   c_en | c_inv | mk(9, 0, 0), 1, 40,  3, 10};
        vecs[5] = '{"en0_inv1", c_inv | mk(9, 5, 0),        1, 40,  0, -1};
        vecs[6] = '{"en0_inv0", mk(9, 5, 0),                0,  0,  0, -1};
        vecs[7] = '{"per0",     c_en | mk(0, 1, 0),         1, 40, 39,  1};
        vecs[8] = '{"inv_d5",   c_en | c_inv | mk(9, 5, 0), 0, 20,  3, 10};
        vecs[9] = '{"pre2",     c_en | mk(4, 2, 2),         1, 16,  1, 20};

        rst_axi = 1'b1;
        ctrl_in = '0;
        repeat (3) step();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_pend", int'(upd_pending), 0);

        // Enabled but never loaded: active DUTY is still zero.
        rst_axi = 1'b0;
        ctrl_in[31:0] = c_en | mk(9, 5, 0);
        hi = 0;
        for (int t = 0; t < 12; t++) begin
            hi += int'(pwm_out[0]);
            step();
        end
        check("post_rst_idle", hi, 0);

        for (int v = 0; v < 10; v++) begin
            start_ch0(vecs[v].ctrl);
            first = int'(pwm_out[0]);
            hi = 0;
            tk = 0;
            ft = -1;
            for (int t = 0; t < 40; t++) begin
                hi += int'(pwm_out[0]);
                if (period_tick[0]) begin
                    tk++;
                    if (ft < 0) ft = t;
                end
                step();
            end
            check({vecs[v].name, "_first"}, first, vecs[v].exp_first);
            check({vecs[v].name, "_high"}, hi, vecs[v].exp_high);
            check({vecs[v].name, "_ticks"}, tk, vecs[v].exp_ticks);
            check({vecs[v].name, "_first_tick"}, ft, vecs[v].exp_ft);
        end

        // Buffered update: DUTY 5->2 with UPD while cnt=3.
        start_ch0(c_en | mk(9, 5, 0));
        pw = '0;
        pd = '0;
        tm = '0;
        for (int t = 0; t < 20; t++) begin
            pw[t] = pwm_out[0];
            pd[t] = upd_pending[0];
            tm[t] = period_tick[0];
            if (t == 2) ctrl_in[31:0] = c_en | c_upd | mk(9, 2, 0);
            step();
        end
        check("upd_pwm", int'(pw), 32'h0000_0C1F);
        check("upd_pend", int'(pd), 32'h0000_01F8);
        check("upd_tick", int'(tm), 32'h0000_0400);

        // Soft reset at cnt=7, held two cycles, then restart from cnt=0.
        start_ch0(c_en | mk(9, 8, 0));
        pw = '0;
        for (int t = 0; t < 20; t++) begin
            pw[t] = pwm_out[0];
            if (t == 6) ctrl_in[31:0] = c_en | c_srst | mk(9, 8, 0);
            if (t == 8) ctrl_in[31:0] = c_en | mk(9, 8, 0);
            step();
        end
        check("srst_pwm", int'(pw), 32'h0009_FE7F);

        // Disabled channel: pending load lands on the very next cycle.
        start_ch0(mk(9, 0, 0));
        ctrl_in[31:0] = c_upd | mk(9, 12, 0);
        step();
        check("en0_pend_set", int'(upd_pending[0]), 1);
        step();
        check("en0_pend_clr", int'(upd_pending[0]), 0);
        ctrl_in[31:0] = c_en | c_upd | mk(9, 12, 0);
        step();
        step();
        check("en0_loaded_pwm", int'(pwm_out[0]), 1);

        // Two channels updated together: ch0 PERIOD=9, ch1 PERIOD=4.
        ctrl_in[31:0]  = c_srst | c_en | mk(9, 5, 0);
        ctrl_in[63:32] = c_srst | c_en | mk(4, 2, 0);
        step();
        ctrl_in[31:0]  = c_en | mk(9, 5, 0);
        ctrl_in[63:32] = c_en | mk(4, 2, 0);
        step();
        pd = '0;
        p1 = '0;
        for (int t = 0; t < 12; t++) begin
            pd[t] = upd_pending[0];
            p1[t] = upd_pending[1];
            if (t == 0) begin
                ctrl_in[31:0]  = c_en | c_upd | mk(9, 3, 0);
                ctrl_in[63:32] = c_en | c_upd | mk(4, 1, 0);
            end
            step();
        end
        check("pair_pend0", int'(pd), 32'h0000_01FE);
`ifdef PWM_BANK_SYNC_EN
        check("pair_pend1", int'(p1), 32'h0000_01FE);
`else
        check("pair_pend1", int'(p1), 32'h0000_000E);
`endif

        // Hard reset while a load is pending and both channels run.
        start_ch0(c_en | mk(9, 12, 0));
        repeat (3) step();
        ctrl_in[31:0] = c_en | c_upd | mk(9, 12, 0);
        step();
        check("mid_pend", int'(upd_pending[0]), 1);
        check("mid_pwm", int'(pwm_out[0]), 1);
        rst_axi = 1'b1;
        step();
        check("mid_rst_pwm", int'(pwm_out), 0);
        check("mid_rst_tick", int'(period_tick), 0);
        check("mid_rst_pend", int'(upd_pending), 0);
        ctrl_in = '0;
        rst_axi = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
